// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// Optional feature macro: BTB_BYPASS_EN (used by btb_predictor).
package btb_pkg;

  localparam int unsigned BtbBitW = 32;
  localparam int unsigned BtbIdxW = 4;
  localparam int unsigned BtbTagW = BtbBitW - BtbIdxW - 1;

  // 2-bit direction counter states
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [BtbTagW-1:0] tag;
    logic [1:0]         cnt;
    logic [BtbBitW-1:0] target;
  } btb_entry_t;

  // Saturating step toward the observed direction
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'b01;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state logic for one entry's 2-bit direction counter.
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       hit_i,
  input  logic       taken_i,
  input  logic       jump_i,
  output logic [1:0] cnt_o
);

  // Jumps force strongly taken; a fresh taken allocation starts weakly taken.
  always_comb begin
    cnt_o = cnt_i;
    if (jump_i) begin
      cnt_o = ST;
    end else if (hit_i) begin
      cnt_o = sat_update(cnt_i, taken_i);
    end else if (taken_i) begin
      cnt_o = WT;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped, tagged branch target buffer with 2-bit direction counters.
// Optional feature macro: BTB_BYPASS_EN forwards a same-cycle update to the lookup.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int unsigned BIT_W = BtbBitW,
  parameter int unsigned IDX_W = BtbIdxW,
  parameter int unsigned TAG_W = BIT_W - IDX_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT_W-1:0] if_pc_i,
  input  logic             if_compressed_i,
  output logic             pred_taken_o,
  output logic [BIT_W-1:0] pred_dest_o,
  output logic             pred_hit_o,
  input  logic             upd_valid_i,
  input  logic             upd_stall_i,
  input  logic [BIT_W-1:0] upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_jump_i,
  input  logic [BIT_W-1:0] upd_target_i
);

  localparam int unsigned Entries = 2 ** IDX_W;

  btb_entry_t tbl_q [Entries];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit, upd_en, upd_wr;
  logic [1:0]       cnt_nxt [Entries];
  btb_entry_t       upd_entry, look_entry;
  logic [BIT_W-1:0] fall_pc;
  logic             unused_pc_lsb;

  // Halfword-granular indexing; bit 0 never participates.
  assign if_idx  = if_pc_i[IDX_W:1];
  assign if_tag  = if_pc_i[BIT_W-1:IDX_W+1];
  assign upd_idx = upd_pc_i[IDX_W:1];
  assign upd_tag = upd_pc_i[BIT_W-1:IDX_W+1];
  assign unused_pc_lsb = ^{if_pc_i[0], upd_pc_i[0]};

  assign upd_hit = tbl_q[upd_idx].valid && (tbl_q[upd_idx].tag == upd_tag);
  assign upd_en  = upd_valid_i && !upd_stall_i;
  // A not-taken miss leaves the table untouched.
  assign upd_wr  = upd_en && (upd_hit || upd_taken_i || upd_jump_i);

  for (genvar e = 0; e < Entries; e++) begin : g_cnt
    btb_sat_counter u_cnt (
      .cnt_i   (tbl_q[e].cnt),
      .hit_i   (upd_hit),
      .taken_i (upd_taken_i),
      .jump_i  (upd_jump_i),
      .cnt_o   (cnt_nxt[e])
    );
  end

  // Post-update contents of the entry addressed by the update PC.
  always_comb begin
    upd_entry       = tbl_q[upd_idx];
    upd_entry.valid = 1'b1;
    upd_entry.tag   = upd_tag;
    upd_entry.cnt   = cnt_nxt[upd_idx];
    if (upd_taken_i || upd_jump_i) upd_entry.target = upd_target_i;
  end

  // Table state: synchronous clear of valids/counters, single-entry training write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].cnt   <= WNT;
      end
    end else if (upd_wr) begin
      tbl_q[upd_idx] <= upd_entry;
    end
  end

  // Select the entry seen by the fetch lookup.
  always_comb begin
    look_entry = tbl_q[if_idx];
`ifdef BTB_BYPASS_EN
    if (upd_wr && (upd_idx == if_idx) && (upd_tag == if_tag)) look_entry = upd_entry;
`endif
  end

  assign fall_pc = if_pc_i + (if_compressed_i ? BIT_W'(2) : BIT_W'(4));

  // Next-PC mux.
  always_comb begin
    pred_hit_o   = look_entry.valid && (look_entry.tag == if_tag);
    pred_taken_o = pred_hit_o && look_entry.cnt[1];
    pred_dest_o  = pred_taken_o ? look_entry.target : fall_pc;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor.
module tb_btb_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc_i;
  logic        if_compressed_i;
  logic        pred_taken_o;
  logic [31:0] pred_dest_o;
  logic        pred_hit_o;
  logic        upd_valid_i;
  logic        upd_stall_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_jump_i;
  logic [31:0] upd_target_i;

  int total = 0;
  int bad   = 0;

  btb_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_pc_i         (if_pc_i),
    .if_compressed_i (if_compressed_i),
    .pred_taken_o    (pred_taken_o),
    .pred_dest_o     (pred_dest_o),
    .pred_hit_o      (pred_hit_o),
    .upd_valid_i     (upd_valid_i),
    .upd_stall_i     (upd_stall_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_jump_i      (upd_jump_i),
    .upd_target_i    (upd_target_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drive a fetch PC and compare hit/taken/dest.
  task automatic look(input string name, input logic [31:0] pc, input logic comp,
                      input logic hit, input logic tkn, input logic [31:0] dest);
    if_pc_i         = pc;
    if_compressed_i = comp;
    #1;
    check({name, ".hit"}, {31'b0, pred_hit_o}, {31'b0, hit});
    check({name, ".taken"}, {31'b0, pred_taken_o}, {31'b0, tkn});
    check({name, ".dest"}, pred_dest_o, dest);
  endtask

  // Apply one unstalled training event.
  task automatic train(input logic [31:0] pc, input logic tkn, input logic jmp,
                       input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_stall_i  = 1'b0;
    upd_pc_i     = pc;
    upd_taken_i  = tkn;
    upd_jump_i   = jmp;
    upd_target_i = tgt;
    tick();
    upd_valid_i  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc_i = 32'h0; if_compressed_i = 1'b0;
    upd_valid_i = 1'b0; upd_stall_i = 1'b0; upd_pc_i = 32'h0;
    upd_taken_i = 1'b0; upd_jump_i = 1'b0; upd_target_i = 32'h0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state: fall-through only
    look("rst_c0", 32'h100, 1'b0, 1'b0, 1'b0, 32'h104);
    look("rst_c1", 32'h100, 1'b1, 1'b0, 1'b0, 32'h102);

    // First taken allocates at WT
    train(32'h100, 1'b1, 1'b0, 32'h200);
    look("alloc", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);

    // Walk the counter down and back up
    train(32'h100, 1'b0, 1'b0, 32'h0);
    look("cnt01", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b0, 1'b0, 32'h0);
    look("cnt00", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b0, 1'b0, 32'h0);
    look("cnt00_sat", 32'h100, 1'b1, 1'b1, 1'b0, 32'h102);
    train(32'h100, 1'b1, 1'b0, 32'h200);
    look("cnt01_up", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
    train(32'h100, 1'b1, 1'b0, 32'h200);
    look("cnt10_up", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
    train(32'h100, 1'b1, 1'b0, 32'h200);
    train(32'h100, 1'b1, 1'b0, 32'h200);
    train(32'h100, 1'b1, 1'b0, 32'h200);
    // Saturated at 11: two not-taken steps reach 01
    train(32'h100, 1'b0, 1'b0, 32'h0);
    look("sat11_nt1", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
    train(32'h100, 1'b0, 1'b0, 32'h0);
    look("sat11_nt2", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);

    // Alias at index 0 replaces the 0x100 entry
    train(32'h120, 1'b1, 1'b0, 32'h300);
    look("alias_old", 32'h100, 1'b0, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h120, 1'b0, 1'b1, 1'b1, 32'h300);
    train(32'h140, 1'b0, 1'b0, 32'h500);
    look("nt_miss_keep", 32'h120, 1'b0, 1'b1, 1'b1, 32'h300);
    look("nt_miss_none", 32'h140, 1'b0, 1'b0, 1'b0, 32'h144);

    // Stall: take 0x120 to 11, then 3 stalled + 1 live not-taken -> 10
    train(32'h120, 1'b1, 1'b0, 32'h300);
    upd_valid_i = 1'b1; upd_stall_i = 1'b1; upd_pc_i = 32'h120;
    upd_taken_i = 1'b0; upd_jump_i = 1'b0; upd_target_i = 32'h0;
    tick(); tick(); tick();
    look("stall_hold", 32'h120, 1'b0, 1'b1, 1'b1, 32'h300);
    upd_stall_i = 1'b0;
    tick();
    upd_valid_i = 1'b0;
    look("stall_one", 32'h120, 1'b0, 1'b1, 1'b1, 32'h300);
    train(32'h120, 1'b0, 1'b0, 32'h0);
    look("stall_pos", 32'h120, 1'b0, 1'b1, 1'b0, 32'h124);

    // Jump miss allocates at ST: one not-taken keeps it taken
    train(32'h160, 1'b1, 1'b1, 32'h400);
    look("jump_alloc", 32'h160, 1'b0, 1'b1, 1'b1, 32'h400);
    train(32'h160, 1'b0, 1'b0, 32'h0);
    look("jump_st", 32'h160, 1'b0, 1'b1, 1'b1, 32'h400);

    // Fall-through adder wraps
    look("wrap", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0000);

    // Same-cycle update (10 -> 01) and lookup of 0x160
    upd_valid_i = 1'b1; upd_stall_i = 1'b0; upd_pc_i = 32'h160;
    upd_taken_i = 1'b0; upd_jump_i = 1'b0; upd_target_i = 32'h0;
`ifdef BTB_BYPASS_EN
    look("same_cycle", 32'h160, 1'b0, 1'b1, 1'b0, 32'h164);
`else
    look("same_cycle", 32'h160, 1'b0, 1'b1, 1'b1, 32'h400);
`endif
    tick();
    upd_valid_i = 1'b0;
    look("after_same", 32'h160, 1'b0, 1'b1, 1'b0, 32'h164);

    // Mid-run reset drops the concurrent update and clears the table
    train(32'h160, 1'b1, 1'b0, 32'h400);
    look("pre_reset", 32'h160, 1'b0, 1'b1, 1'b1, 32'h400);
    rst_n = 1'b0;
    upd_valid_i = 1'b1; upd_stall_i = 1'b0; upd_pc_i = 32'h182;
    upd_taken_i = 1'b1; upd_jump_i = 1'b0; upd_target_i = 32'h600;
    tick();
    rst_n = 1'b1;
    upd_valid_i = 1'b0;
    look("post_reset_a", 32'h160, 1'b0, 1'b0, 1'b0, 32'h164);
    look("post_reset_b", 32'h182, 1'b0, 1'b0, 1'b0, 32'h186);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Branch target buffer and direction predictor feeding the IF stage.
- Lookup side: given the fetch PC, produces the predicted next PC. This value travels down the pipeline as pred_dest and is checked in EX.
- Update side: consumes EX-stage feedback (valid, actual taken, resolved target) and trains the table.
- Storage: direct-mapped, tagged. Each entry holds a 2-bit saturating counter and a target register.

Parameters:
BIT_W, 32, PC/target width
IDX_W, 4, index bits; ENTRIES = 2**IDX_W
TAG_W, BIT_W-IDX_W-1, tag width; the tag is pc[BIT_W-1:IDX_W+1]

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
if_pc_i  input  BIT_W  fetch PC to predict
if_compressed_i  input  1  fetched instruction is 16-bit
pred_taken_o  output  1  predicted taken (table hit and counter MSB set)
pred_dest_o  output  BIT_W  predicted next PC
pred_hit_o  output  1  valid entry with matching tag
upd_valid_i  input  1  EX feedback valid (branch or jump in EX)
upd_stall_i  input  1  EX held this cycle; the update is ignored
upd_pc_i  input  BIT_W  PC of the resolved instruction
upd_taken_i  input  1  actual taken
upd_jump_i  input  1  resolved instruction is jal/jalr
upd_target_i  input  BIT_W  resolved target address

Behaviour:
- Clock and reset: reset rst_n, synchronous, active-low; clock clk.
- Reset clears all valid bits, sets all counters to 2'b01, and leaves targets and tags don't-care. Reset asserted mid-operation clears the table in that single cycle; any update in that cycle is dropped.
- Index and tag: index = pc[IDX_W:1], halfword granularity. tag = pc[BIT_W-1:IDX_W+1].
- Lookup (combinational from the registered table, 0-cycle latency):
  - hit = valid[idx] && tag[idx]==tag(if_pc_i)
  - pred_taken_o = hit && cnt[idx][1]
  - pred_dest_o = pred_taken_o ? target[idx] : if_pc_i + (if_compressed_i ? 2 : 4); the adder wraps mod 2**BIT_W.
  - After reset: pred_taken_o=0, pred_hit_o=0, pred_dest_o equals the fall-through PC.
- Update (registered, visible to a lookup on the next cycle) occurs only when upd_valid_i && !upd_stall_i, which gives exactly one training event per resolved instruction.
  - Hit, jump: cnt<=2'b11; target<=upd_target_i.
  - Hit, branch taken: cnt<=sat(cnt+1); target<=upd_target_i.
  - Hit, branch not taken: cnt<=sat(cnt-1); target unchanged.
  - Miss, taken or jump: allocate and overwrite any alias. valid<=1, tag written, target written, cnt <= jump ? 2'b11 : 2'b10.
  - Miss, not taken: no allocation, table unchanged.
- Counter saturation: counters stay in 2'b00..2'b11; 11+1=11 and 00-1=00.
- Simultaneous lookup and update to the same index in one cycle: the lookup sees the pre-update entry (no bypass), unless the optional feature below is compiled in.
- State per entry: valid, tag, cnt, target. There is no FSM; the counters form a 4-state machine per entry (SNT=00, WNT=01, WT=10, ST=11).

Optional Feature:
BTB_BYPASS_EN
- Defined: when an update is applied in the same cycle and upd_pc_i's index and tag match if_pc_i, the lookup uses the post-update entry values combinationally.
- Undefined: no bypass; the lookup reads the registered table only.

Decomposition:
- Shared package (btb_pkg):
  - counter state constants SNT/WNT/WT/ST
  - a function sat_update(cnt, taken) returning the next counter value
  - an entry struct {valid, tag, cnt, target}
- Natural sub-module: btb_sat_counter, the 2-bit saturating update logic, one instance per entry.
- Top level holds the entry arrays, index/tag extraction, allocation logic and the next-PC mux.

Test Plan:
- Reset, then lookup 0x100, compressed=0 -> hit=0, taken=0, dest=0x104; compressed=1 -> dest=0x102.
- Update pc=0x100, taken=1, target=0x200 -> next cycle lookup 0x100 gives hit=1, taken=1, dest=0x200 (cnt=10).
- From cnt=10: two not-taken updates -> cnt=00, dest=0x104. One taken -> cnt=01, still not taken. A second taken -> cnt=10, dest=0x200. Further taken updates saturate at 11.
- Alias: after the 0x100 entry exists, update pc=0x120 (same index 0, tag 9), taken, target 0x300. Lookup 0x100 -> miss, dest=0x104; lookup 0x120 -> dest=0x300. A not-taken miss on 0x140 -> 0x120 entry unchanged.
- Stall: upd_valid_i=1 with upd_stall_i=1 for 3 cycles, then 1 cycle unstalled -> exactly one counter step. A jump update on a miss -> cnt=11.
- Same-cycle update and lookup of 0x100: without BTB_BYPASS_EN, the old prediction in that cycle; with it, the new one. Reset asserted mid-run -> every lookup misses on the next cycle.
